led_pattern_gen: RTL
====================

Name: led_pattern_gen

Overview:
- Multi-channel LED pattern generator, successor to the fixed-delay signal generator plus switch pair.
- Each channel has runtime-programmable mode (off / on / blink / PWM), period and duty.
- Sits between the board-level config logic and the led pins.
- Channel count and counter width are parameters.

Parameters:
- CHANNELS, 3, number of independent LED channels (1..16).
- CNT_W, 24, width of the period, duty and counter fields.
- RESET_PERIOD, 24'd5, period value loaded into every channel at reset; must fit in CNT_W bits.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst_n  in  1  synchronous, active-low reset.
- enable  in  1  global run; 0 freezes all blink/PWM counters.
- cfg_we  in  1  config write strobe, single cycle.
- cfg_ch  in  4  target channel index.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM.
- cfg_period  in  CNT_W  period value P; one period is P+1 cycles.
- cfg_duty  in  CNT_W  PWM high-cycle count D.
- cfg_err  out  1  one-cycle pulse when a write targets cfg_ch >= CHANNELS.
- wrap  out  CHANNELS  per-channel one-cycle pulse on counter wrap.
- led  out  CHANNELS  LED drive, registered.

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-low (rst_n).
  - rst_n=0 sampled at a clk edge sets every channel to mode=OFF, period=RESET_PERIOD, duty=0, cnt=0, led=0, wrap=0, and sets cfg_err=0.
  - Reset overrides every other input, including mid-operation and coincident writes.
- Config write (cfg_we=1, cfg_ch<CHANNELS), applied at the clk edge:
  - Load mode, period and duty into the target channel; clear its cnt to 0.
  - New behaviour is visible on led from the next cycle (1-cycle latency).
  - The write has priority over a wrap or counter update in the same cycle; no wrap pulse is issued that cycle.
  - Other channels are unaffected.
- Invalid write (cfg_we=1, cfg_ch>=CHANNELS): no state change; cfg_err=1 for exactly the following cycle.
- Counter (BLINK/PWM only, enable=1):
  - If cnt==P: cnt<=0 and wrap[i]=1 for the next cycle.
  - Otherwise cnt<=cnt+1.
  - Unsigned arithmetic, CNT_W bits; P=2^CNT_W-1 is legal (period 2^CNT_W cycles).
- enable=0: cnt, led and wrap state are held; wrap outputs are 0 while held. OFF/ON channels ignore enable.
- Per-mode output:
  - OFF: led=0, cnt held at 0.
  - ON: led=1, cnt held at 0.
  - BLINK:
    - led toggles on every wrap, so the level is constant for P+1 cycles and the full period is 2(P+1).
    - After a write, led starts at 0.
    - P=0 toggles every enabled cycle.
  - PWM:
    - In every cycle, led == (cnt < D); implemented as a register fed from next-state cnt, so there is no combinational path from cfg inputs to led.
    - D=0 gives constant 0. D>=P+1 gives constant 1.
    - After a write, the first cycle of the period has led=(D>0).
- Channel state machine (per channel): OFF, ON, BLINK, PWM.
  - Transitions occur only via a valid config write or reset.
  - Any-to-any transition is allowed.
  - Re-writing the same mode restarts the phase (cnt=0; BLINK led=0).
- No internal buffering; back-to-back writes on consecutive cycles are all accepted.

Decomposition:
- Package led_pattern_pkg:
  - mode enum: MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2, MODE_PWM=2'd3.
  - constant CH_IDX_W=4.
- Sub-module led_channel (one per channel, via a generate loop):
  - Holds mode, period, duty, cnt and led registers.
  - Inputs: clk, rst_n, enable, a per-channel write strobe and the cfg fields.
  - Outputs: led and wrap.
- Top level: cfg_ch decode, cfg_err register, generate loop.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with cfg_we=1 -> led=0, wrap=0, cfg_err=0. After release, all channels are OFF.
- BLINK: write ch0 mode=2 P=4 -> led[0] low 5 cycles, high 5, low 5. wrap[0] pulses every 5 cycles. led[1], led[2] stay 0.
- PWM: write ch1 mode=3 P=9 D=3 -> led[1] is 1 for 3 of every 10 cycles. D=0 gives constant 0; D=10 gives constant 1.
- enable: ch0 BLINK P=4, drop enable for 7 cycles mid-period -> led[0] and cnt freeze. On re-enable, the remaining high time completes (total high = 5 enabled cycles).
- Write collision: rewrite ch0 with P=2 on the exact cycle cnt==P -> no wrap pulse; cnt=0, led=0 next cycle; new period 3.
- Invalid and mid-operation reset: write cfg_ch=5 (CHANNELS=3) -> cfg_err high 1 cycle, no state change. Assert rst_n=0 while ch1 is running PWM -> all led=0 at the next edge; ch1 mode returns to OFF.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
package led_pattern_pkg;

   localparam int CH_IDX_W = 4;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its own mode/period/duty, a free-running phase counter
// and a registered LED output with a one-cycle wrap pulse.
module led_channel
   import led_pattern_pkg::*;
#(
   parameter int                CNT_W        = 24,
   parameter logic [CNT_W-1:0]  RESET_PERIOD = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   input  logic             wr_en_i,
   input  logic [1:0]       mode_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] duty_i,
   output logic             led_o,
   output logic             wrap_o
);

   mode_e            mode_q,   mode_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] duty_q,   duty_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             led_q,    led_d;
   logic             wrap_q,   wrap_d;
   logic             at_end;

   assign at_end = (cnt_q == period_q);

   always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      duty_d   = duty_q;
      cnt_d    = cnt_q;
      led_d    = led_q;
      wrap_d   = 1'b0;
      if (wr_en_i) begin
         // A write restarts the phase and wins over any wrap due this cycle.
         mode_d   = mode_e'(mode_i);
         period_d = period_i;
         duty_d   = duty_i;
         cnt_d    = '0;
         case (mode_e'(mode_i))
            MODE_ON:  led_d = 1'b1;
            MODE_PWM: led_d = (duty_i != '0);
            default:  led_d = 1'b0;
         endcase
      end else begin
         case (mode_q)
            MODE_OFF: begin
               cnt_d = '0;
               led_d = 1'b0;
            end
            MODE_ON: begin
               cnt_d = '0;
               led_d = 1'b1;
            end
            default: begin
               if (enable_i) begin
                  if (at_end) begin
                     cnt_d  = '0;
                     wrap_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
                  // PWM compares the next count so led tracks (cnt < duty) every cycle.
                  if (mode_q == MODE_BLINK) begin
                     if (at_end) led_d = ~led_q;
                  end else begin
                     led_d = (cnt_d < duty_q);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q   <= MODE_OFF;
         period_q <= RESET_PERIOD;
         duty_q   <= '0;
         cnt_q    <= '0;
         led_q    <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         cnt_q    <= cnt_d;
         led_q    <= led_d;
         wrap_q   <= wrap_d;
      end
   end

   assign led_o  = led_q;
   assign wrap_o = wrap_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: decodes config writes to per-channel
// strobes and flags writes aimed at channels that do not exist.
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int                CHANNELS     = 3,
   parameter int                CNT_W        = 24,
   parameter logic [CNT_W-1:0]  RESET_PERIOD = 24'd5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   input  logic                cfg_we,
   input  logic [CH_IDX_W-1:0] cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [CNT_W-1:0]    cfg_period,
   input  logic [CNT_W-1:0]    cfg_duty,
   output logic                cfg_err,
   output logic [CHANNELS-1:0] wrap,
   output logic [CHANNELS-1:0] led
);

   localparam logic [CH_IDX_W:0] CH_LIMIT = (CH_IDX_W + 1)'(CHANNELS);

   logic                cfg_err_q, cfg_err_d;
   logic [CHANNELS-1:0] ch_we;

   assign cfg_err_d = cfg_we && ({1'b0, cfg_ch} >= CH_LIMIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg_err = cfg_err_q;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         assign ch_we[gi] = cfg_we && (cfg_ch == CH_IDX_W'(gi));

         led_channel #(
            .CNT_W        (CNT_W),
            .RESET_PERIOD (RESET_PERIOD)
         ) u_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .enable_i (enable),
            .wr_en_i  (ch_we[gi]),
            .mode_i   (cfg_mode),
            .period_i (cfg_period),
            .duty_i   (cfg_duty),
            .led_o    (led[gi]),
            .wrap_o   (wrap[gi])
         );
      end
   endgenerate

endmodule
